// File: rtl/joydecoder_multi.sv
// Serial joystick decoder for a daisy-chained parallel-in/serial-out chain.
// Loads the chain, clocks out NJOY*NBITS bits MSB-first, then commits a
// whole-frame snapshot to joy_state with a one-cycle frame_strobe.
module joydecoder_multi #(
  parameter int NJOY       = 2,
  parameter int NBITS      = 8,
  parameter int CLKDIV     = 4,
  parameter int GAP_TICKS  = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  joy_data,
  output logic                  joy_clk,
  output logic                  joy_load_n,
  output logic [NJOY*NBITS-1:0] joy_state,
  output logic                  frame_strobe
);

  localparam int TOTAL = NJOY * NBITS;
  localparam int IDX_W = $clog2(TOTAL);
  localparam int PRE_W = $clog2(CLKDIV);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKDIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(GAP_TICKS);

  typedef enum logic [2:0] {
    S_GAP,
    S_LOAD,
    S_SAMPLE,
    S_HIGH,
    S_COMMIT
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [PRE_W-1:0]   pre_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [IDX_W-1:0]   idx;
  logic [TOTAL-1:0]   shift_reg;
  logic               tick;
  logic               joy_clk_d;
  logic               joy_load_n_d;

  assign tick = (pre_cnt == PRE_LAST);

  // Prescaler: free-running tick generator, realigned at every commit.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (state == S_COMMIT || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_GAP;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; GAP only exits once the gap count is complete and enable is high.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    unique case (state)
      S_GAP:    if (tick && enable && (gap_cnt >= GAP_LAST)) next_state = S_LOAD;
      S_LOAD:   if (tick) next_state = S_SAMPLE;
      S_SAMPLE: if (tick) next_state = S_HIGH;
      S_HIGH:   if (tick) next_state = (idx == IDX_LAST) ? S_COMMIT : S_SAMPLE;
      S_COMMIT: next_state = S_GAP;
      default:  next_state = S_GAP;
    endcase
  end

  // Output decode from the next state, so the pins come straight off flops.
  always_comb begin
    joy_clk_d    = (next_state == S_HIGH);
    joy_load_n_d = (next_state != S_LOAD);
  end

  // Registered chain controls: glitch-free, load and clock never overlap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      joy_clk    <= 1'b0;
      joy_load_n <= 1'b1;
    end else begin
      joy_clk    <= joy_clk_d;
      joy_load_n <= joy_load_n_d;
    end
  end

  // Gap counter: counts idle ticks, saturates while scanning is disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (state == S_COMMIT) begin
      gap_cnt <= '0;
    end else if (state == S_GAP && tick && gap_cnt != GAP_SAT) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  // Bit index and shift capture; first bit out of the chain lands in the MSB.
  always_ff @(posedge clk) begin
    // NOTE: the shift register is reset too, so an aborted frame can never
    // leave stale bits that a later commit would expose.
    if (!rst_n) begin
      idx       <= '0;
      shift_reg <= '0;
    end else begin
      if (state == S_LOAD && tick) begin
        idx <= '0;
      end else if (state == S_HIGH && tick && idx != IDX_LAST) begin
        idx <= idx + IDX_W'(1);
      end
      if (state == S_SAMPLE && tick) begin
        shift_reg[IDX_LAST - idx] <= joy_data;
      end
    end
  end

  // Commit: only a complete frame reaches joy_state, flagged by a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      joy_state    <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= (state == S_COMMIT);
      if (state == S_COMMIT) begin
        joy_state <= ACTIVE_LOW ? ~shift_reg : shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_joydecoder_multi.sv
// Bench for joydecoder_multi: a behavioural 2x8 shift-register chain feeds the
// default build, a scoreboard checks each committed frame, and a second
// NJOY=1/NBITS=12/CLKDIV=2 build runs with its data line tied high.
`timescale 1ns/1ps
module tb_joydecoder_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        joy_data;
  logic        joy_clk, joy_load_n, frame_strobe;
  logic [15:0] joy_state;

  logic        joy_data2 = 1'b1;
  logic        joy_clk2, joy_load_n2, frame_strobe2;
  logic [11:0] joy_state2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  joydecoder_multi dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .joy_data(joy_data),
    .joy_clk(joy_clk), .joy_load_n(joy_load_n),
    .joy_state(joy_state), .frame_strobe(frame_strobe)
  );

  joydecoder_multi #(.NJOY(1), .NBITS(12), .CLKDIV(2), .GAP_TICKS(2), .ACTIVE_LOW(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(1'b1), .joy_data(joy_data2),
    .joy_clk(joy_clk2), .joy_load_n(joy_load_n2),
    .joy_state(joy_state2), .frame_strobe(frame_strobe2)
  );

  // Chain model: parallel load while load_n is low, shift on joy_clk rising.
  logic [15:0] chain_pat = 16'h5AC3;
  logic [15:0] ch = '0;
  logic        ch_clk_q = 1'b0;
  always @(posedge clk) begin
    if (joy_load_n === 1'b0) ch <= chain_pat;
    else if (joy_clk === 1'b1 && !ch_clk_q) ch <= {ch[14:0], 1'b0};
    ch_clk_q <= (joy_clk === 1'b1);
  end
  assign joy_data = ch[15];

  // Scoreboard and pin monitor.
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;
  int  load_falls = 0;
  int  strobes = 0;
  int  rise_cnt = 0;
  int  last_rises = 0;
  bit  prev_load_n = 1'b1, prev_clk = 1'b0, prev_strobe = 1'b0, overlap = 1'b0;
  time t_strobe = 0;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (prev_load_n && joy_load_n === 1'b0) begin
        exp_q.push_back(~chain_pat);
        load_falls++;
        rise_cnt = 0;
      end
      if (!prev_clk && joy_clk === 1'b1) rise_cnt++;
      if (joy_load_n === 1'b0 && joy_clk === 1'b1) overlap = 1'b1;
      if (frame_strobe === 1'b1) begin
        strobes++;
        last_rises = rise_cnt;
        checks++;
        if (prev_strobe) begin
          failures++;
          $display("FAIL strobe_width: frame_strobe high for more than one cycle");
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe: strobe with no frame pending, joy_state=%h", joy_state);
        end else begin
          exp_v = exp_q.pop_front();
          if (joy_state !== exp_v) begin
            failures++;
            $display("FAIL sb_joy_state: got %h expected %h", joy_state, exp_v);
          end
        end
      end
    end
    prev_load_n = (joy_load_n !== 1'b0);
    prev_clk    = (joy_clk === 1'b1);
    prev_strobe = (frame_strobe === 1'b1);
  end

  task automatic wait_strobe(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (frame_strobe === 1'b1) begin
        ok = 1'b1;
        t_strobe = $time;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: no frame_strobe within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_load(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (joy_load_n === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (joy_clk !== 1'b0) begin failures++; $display("FAIL %s_joy_clk: got %b expected 0", name, joy_clk); end
    checks++;
    if (joy_load_n !== 1'b1) begin failures++; $display("FAIL %s_load_n: got %b expected 1", name, joy_load_n); end
    checks++;
    if (frame_strobe !== 1'b0) begin failures++; $display("FAIL %s_strobe: got %b expected 0", name, frame_strobe); end
    checks++;
    if (joy_state !== 16'h0000) begin failures++; $display("FAIL %s_joy_state: got %h expected 0000", name, joy_state); end
  endtask

  task automatic test_reset();
    int n;
    int w;
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_load(50, n);
    checks++;
    if (n !== 8) begin failures++; $display("FAIL first_load: load_n fell after %0d cycles, expected 8", n); end
    w = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (joy_load_n === 1'b1) break;
      w++;
    end
    checks++;
    if (w !== 4) begin failures++; $display("FAIL load_width: load_n low %0d cycles, expected 4", w); end
    checks++;
    if (joy_state !== 16'h0000) begin failures++; $display("FAIL state_before_commit: got %h expected 0000", joy_state); end
  endtask

  task automatic test_frame();
    wait_strobe(300, "frame_timeout");
    @(posedge clk);
    #1;
    checks++;
    if (joy_state !== 16'hA53C) begin failures++; $display("FAIL frame_value: got %h expected a53c", joy_state); end
    checks++;
    if (last_rises !== 16) begin failures++; $display("FAIL clk_edges: got %0d joy_clk rises expected 16", last_rises); end
  endtask

  task automatic test_period();
    logic [15:0] pats [3] = '{16'h0000, 16'hFFFF, 16'h1234};
    time t0;
    int  per;
    wait_strobe(300, "period_sync");
    for (int k = 0; k < 3; k++) begin
      t0 = t_strobe;
      chain_pat = pats[k];
      wait_strobe(300, "period_timeout");
      per = int'((t_strobe - t0) / 10);
      checks++;
      if (per !== 141) begin failures++; $display("FAIL period: got %0d cycles expected 141", per); end
      checks++;
      if (joy_state !== ~pats[k]) begin failures++; $display("FAIL period_value: got %h expected %h", joy_state, ~pats[k]); end
    end
  endtask

  task automatic test_enable_drop();
    int n;
    int lf;
    chain_pat = 16'h0F0F;
    wait_load(300, n);
    @(posedge clk);
    #1;
    for (int i = 0; i < 200 && rise_cnt < 5; i++) begin
      @(posedge clk);
      #1;
    end
    enable = 1'b0;
    wait_strobe(300, "drop_timeout");
    checks++;
    if (joy_state !== 16'hF0F0) begin failures++; $display("FAIL drop_commit: got %h expected f0f0", joy_state); end
    lf = load_falls;
    repeat (400) @(posedge clk);
    #1;
    checks++;
    if (load_falls !== lf) begin failures++; $display("FAIL drop_idle: %0d loads while disabled, expected 0", load_falls - lf); end
    checks++;
    if (joy_state !== 16'hF0F0) begin failures++; $display("FAIL drop_hold: got %h expected f0f0", joy_state); end
    enable = 1'b1;
    wait_load(20, n);
    checks++;
    if (n < 1 || n > 4) begin failures++; $display("FAIL resume: load_n fell after %0d cycles, expected 1..4", n); end
    wait_strobe(300, "resume_timeout");
  endtask

  task automatic test_reset_mid();
    int n;
    int s;
    chain_pat = 16'hBEEF;
    wait_load(300, n);
    @(posedge clk);
    #1;
    for (int i = 0; i < 200 && rise_cnt < 9; i++) begin
      @(posedge clk);
      #1;
    end
    s = strobes;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    wait_load(50, n);
    checks++;
    if (n !== 8) begin failures++; $display("FAIL mid_restart: load_n fell after %0d cycles, expected 8", n); end
    checks++;
    if (strobes !== s) begin failures++; $display("FAIL mid_no_strobe: %0d strobes after abort, expected 0", strobes - s); end
    wait_strobe(300, "mid_timeout");
    checks++;
    if (joy_state !== 16'h4110) begin failures++; $display("FAIL mid_frame_value: got %h expected 4110", joy_state); end
  endtask

  task automatic test_second_build();
    time t[2];
    bit  ok;
    int  per;
    for (int k = 0; k < 2; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk);
        #1;
        if (frame_strobe2 === 1'b1) begin ok = 1'b1; t[k] = $time; break; end
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL b2_timeout: no strobe within 200 cycles"); end
      checks++;
      if (joy_state2 !== 12'h000) begin failures++; $display("FAIL b2_state: got %h expected 000", joy_state2); end
    end
    per = int'((t[1] - t[0]) / 10);
    checks++;
    if (per !== 55) begin failures++; $display("FAIL b2_period: got %0d cycles expected 55", per); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_frame();
    test_period();
    test_enable_drop();
    test_reset_mid();
    test_second_build();
    checks++;
    if (overlap) begin failures++; $display("FAIL overlap: joy_clk high with load_n low, expected never"); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
